// File: rtl/edge_img_streamer_pkg.sv
// Shared constants, state encoding and pixel-lane slicing for the edge-detection
// chip pixel interface.
package edge_img_streamer_pkg;

    localparam int unsigned BIT_LENGTH   = 5;
    localparam int unsigned IMG_DIM      = 20;
    localparam int unsigned PIX_PER_WORD = 5;
    localparam int unsigned BEATS        = IMG_DIM * IMG_DIM / PIX_PER_WORD;
    localparam int unsigned MEM_W        = PIX_PER_WORD * BIT_LENGTH;
    localparam int unsigned ADDR_W       = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_COLLECT,
        S_FLUSH
    } state_t;

    // LSB of pixel lane p inside a memory word
    function automatic int unsigned lane_lsb(input int unsigned p);
        return p * BIT_LENGTH;
    endfunction

endpackage

// File: rtl/edge_bit_packer.sv
// Packs the chip's serial edge bits into WORD_W-bit words, first bit in the LSB,
// and emits a trailing partial word on flush.
module edge_bit_packer
    import edge_img_streamer_pkg::*;
#(
    parameter int unsigned WORD_W   = 20,
    parameter int unsigned OUT_BITS = 400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              take,
    input  logic              bit_in,
    input  logic              flush,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic              last_bit_c,
    output logic              word_full_c
);

    localparam int unsigned POS_W = $clog2(WORD_W);
    localparam int unsigned CNT_W = $clog2(OUT_BITS + 1);

    logic [WORD_W-1:0] sr;
    logic [POS_W-1:0]  pos;
    logic [CNT_W-1:0]  cnt;

    assign last_bit_c  = (cnt == CNT_W'(OUT_BITS - 1));
    assign word_full_c = (pos == POS_W'(WORD_W - 1));

    // The completing bit is merged straight into the emitted word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr         <= '0;
            pos        <= '0;
            cnt        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                sr  <= '0;
                pos <= '0;
                cnt <= '0;
            end else if (flush) begin
                word       <= sr;
                word_valid <= 1'b1;
                sr         <= '0;
                pos        <= '0;
            end else if (take) begin
                cnt <= cnt + CNT_W'(1);
                if (word_full_c) begin
                    word       <= sr | (WORD_W'(bit_in) << pos);
                    word_valid <= 1'b1;
                    sr         <= '0;
                    pos        <= '0;
                end else begin
                    sr[pos] <= bit_in;
                    pos     <= pos + POS_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/edge_img_streamer.sv
// Host-side driver: fetches a frame from word memory, streams it to the edge
// chip five pixels per beat, then collects and packs the serial edge result.
module edge_img_streamer
    import edge_img_streamer_pkg::*;
#(
    parameter int unsigned OUT_BITS = 400,
    parameter int unsigned WORD_W   = 20,
    parameter int unsigned TIMEOUT  = 4095
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  mem_rd,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [MEM_W-1:0]      mem_data,
    output logic [BIT_LENGTH-1:0] pixel_out0,
    output logic [BIT_LENGTH-1:0] pixel_out1,
    output logic [BIT_LENGTH-1:0] pixel_out2,
    output logic [BIT_LENGTH-1:0] pixel_out3,
    output logic [BIT_LENGTH-1:0] pixel_out4,
    output logic                  load_end,
    input  logic                  edge_in,
    input  logic                  readable_in,
    output logic [WORD_W-1:0]     edge_word,
    output logic                  edge_word_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BEATS - 1);

    state_t             state, state_n;
    logic               mem_rd_n, done_n, timeout_err_n;
    logic [ADDR_W-1:0]  mem_addr_n;
    logic [IDLE_W-1:0]  idle_cnt, idle_cnt_n;
    logic               rd_d1, last_d1;
    logic [MEM_W-1:0]   pix_word;
    logic               take_c, last_bit_c, word_full_c;

    assign take_c = (state == S_COLLECT) && readable_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            state       <= state_n;
            mem_rd      <= mem_rd_n;
            mem_addr    <= mem_addr_n;
            busy        <= (state_n != S_IDLE);
            done        <= done_n;
            timeout_err <= timeout_err_n;
            idle_cnt    <= idle_cnt_n;
        end
    end

    always_comb begin
        state_n       = state;
        mem_rd_n      = 1'b0;
        mem_addr_n    = '0;
        done_n        = 1'b0;
        timeout_err_n = timeout_err;
        idle_cnt_n    = idle_cnt;
        case (state)
            S_IDLE: begin
                idle_cnt_n = '0;
                if (start) begin
                    state_n       = S_FETCH;
                    mem_rd_n      = 1'b1;
                    timeout_err_n = 1'b0;
                end
            end
            S_FETCH: begin
                if (mem_addr != LAST_ADDR) begin
                    mem_rd_n   = 1'b1;
                    mem_addr_n = mem_addr + ADDR_W'(1);
                end else begin
                    state_n = S_DRAIN;
                end
            end
            // Wait until the last beat is on the pixel lanes
            S_DRAIN: begin
                if (load_end) begin
                    state_n = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (take_c) begin
                    idle_cnt_n = '0;
                    if (last_bit_c) begin
                        if (word_full_c) begin
                            state_n = S_IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = S_FLUSH;
                        end
                    end
                end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                    timeout_err_n = 1'b1;
                    state_n       = S_IDLE;
                end else begin
                    idle_cnt_n = idle_cnt + IDLE_W'(1);
                end
            end
            S_FLUSH: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Memory returns data one cycle after the read; register it onto the lanes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_d1    <= 1'b0;
            last_d1  <= 1'b0;
            load_end <= 1'b0;
            pix_word <= '0;
        end else begin
            rd_d1    <= mem_rd;
            last_d1  <= mem_rd && (mem_addr == LAST_ADDR);
            load_end <= rd_d1 && last_d1;
            pix_word <= rd_d1 ? mem_data : '0;
        end
    end

    assign pixel_out0 = pix_word[lane_lsb(0) +: BIT_LENGTH];
    assign pixel_out1 = pix_word[lane_lsb(1) +: BIT_LENGTH];
    assign pixel_out2 = pix_word[lane_lsb(2) +: BIT_LENGTH];
    assign pixel_out3 = pix_word[lane_lsb(3) +: BIT_LENGTH];
    assign pixel_out4 = pix_word[lane_lsb(4) +: BIT_LENGTH];

    edge_bit_packer #(
        .WORD_W   (WORD_W),
        .OUT_BITS (OUT_BITS)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear       (state == S_IDLE),
        .take        (take_c),
        .bit_in      (edge_in),
        .flush       (state == S_FLUSH),
        .word        (edge_word),
        .word_valid  (edge_word_valid),
        .last_bit_c  (last_bit_c),
        .word_full_c (word_full_c)
    );

endmodule

// File: tb/tb_edge_img_streamer.sv
// Scoreboard bench: a default instance for the pixel stream, packing and the
// full timeout, and a small instance (30 bits, timeout 16) for flush/timeout.
module tb_edge_img_streamer;

    typedef struct packed {
        logic        mem_rd;
        logic [6:0]  addr;
        logic [24:0] pix;
        logic        load_end;
        logic        busy;
    } cyc_t;

    typedef struct packed {
        logic [19:0] w;
        logic        d;
    } wexp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic        start_a = 1'b0, edge_a = 1'b0, readable_a = 1'b0;
    logic        mem_rd_a, load_end_a, wv_a, busy_a, done_a, err_a;
    logic [6:0]  mem_addr_a;
    logic [24:0] mem_data_a = '0;
    logic [4:0]  pa0, pa1, pa2, pa3, pa4;
    logic [19:0] word_a;

    logic        start_b = 1'b0, edge_b = 1'b0, readable_b = 1'b0;
    logic        mem_rd_b, load_end_b, wv_b, busy_b, done_b, err_b;
    logic [6:0]  mem_addr_b;
    logic [24:0] mem_data_b = '0;
    logic [4:0]  pb0, pb1, pb2, pb3, pb4;
    logic [19:0] word_b;

    cyc_t  exp_cyc[$];
    wexp_t exp_a[$];
    wexp_t exp_b[$];
    cyc_t  cyc_got, cyc_exp;
    wexp_t we_a, we_b;
    int    checks = 0;
    int    errors = 0;

    edge_img_streamer u_dut (
        .clk(clk), .reset(reset), .start(start_a),
        .mem_rd(mem_rd_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
        .pixel_out0(pa0), .pixel_out1(pa1), .pixel_out2(pa2),
        .pixel_out3(pa3), .pixel_out4(pa4), .load_end(load_end_a),
        .edge_in(edge_a), .readable_in(readable_a),
        .edge_word(word_a), .edge_word_valid(wv_a),
        .busy(busy_a), .done(done_a), .timeout_err(err_a)
    );

    edge_img_streamer #(.OUT_BITS(30), .WORD_W(20), .TIMEOUT(16)) u_small (
        .clk(clk), .reset(reset), .start(start_b),
        .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
        .pixel_out0(pb0), .pixel_out1(pb1), .pixel_out2(pb2),
        .pixel_out3(pb3), .pixel_out4(pb4), .load_end(load_end_b),
        .edge_in(edge_b), .readable_in(readable_b),
        .edge_word(word_b), .edge_word_valid(wv_b),
        .busy(busy_b), .done(done_b), .timeout_err(err_b)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] word_of(input int k);
        logic [4:0] v;
        v = 5'(k % 32);
        return {v, v, v, v, v};
    endfunction

    always @(posedge clk) begin
        mem_data_a <= mem_rd_a ? word_of(int'(mem_addr_a)) : 25'd0;
        mem_data_b <= mem_rd_b ? word_of(int'(mem_addr_b)) : 25'd0;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle expectation for cycles 1..84 after the start edge
    task automatic push_frame();
        for (int c = 1; c <= 84; c++) begin
            cyc_t e;
            e.mem_rd   = (c <= 80);
            e.addr     = (c <= 80) ? 7'(c - 1) : 7'd0;
            e.pix      = (c >= 3 && c <= 82) ? word_of(c - 3) : 25'd0;
            e.load_end = (c == 82);
            e.busy     = 1'b1;
            exp_cyc.push_back(e);
        end
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        push_frame();
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic wait_empty(input string name, input bit use_a);
        for (int k = 0; k < 20; k++) begin
            if ((use_a ? exp_a.size() : exp_b.size()) == 0) break;
            @(negedge clk);
        end
        check(name, 64'(use_a ? exp_a.size() : exp_b.size()), 64'd0);
    endtask

    // Pixel-stream monitor
    always @(posedge clk) begin
        #1;
        if (exp_cyc.size() != 0) begin
            cyc_exp          = exp_cyc.pop_front();
            cyc_got.mem_rd   = mem_rd_a;
            cyc_got.addr     = mem_addr_a;
            cyc_got.pix      = {pa4, pa3, pa2, pa1, pa0};
            cyc_got.load_end = load_end_a;
            cyc_got.busy     = busy_a;
            check("frame_cycle", 64'(cyc_got), 64'(cyc_exp));
        end
    end

    // Edge-word monitors: each strobe pops one expected {word, done}
    always @(posedge clk) begin
        #1;
        if (wv_a) begin
            if (exp_a.size() == 0) begin
                check("word_a_unexpected", 64'(wv_a), 64'd0);
            end else begin
                we_a = exp_a.pop_front();
                check("word_a", 64'({word_a, done_a}), 64'(we_a));
            end
        end else if (done_a) begin
            check("done_a_without_word", 64'(done_a), 64'd0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (wv_b) begin
            if (exp_b.size() == 0) begin
                check("word_b_unexpected", 64'(wv_b), 64'd0);
            end else begin
                we_b = exp_b.pop_front();
                check("word_b", 64'({word_b, done_b}), 64'(we_b));
            end
        end else if (done_b) begin
            check("done_b_without_word", 64'(done_b), 64'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 reset = 1'b1;
        #1;
        check("reset_a", 64'({mem_rd_a, mem_addr_a, pa4, pa3, pa2, pa1, pa0, load_end_a,
                              word_a, wv_a, busy_a, done_a, err_a}), 64'd0);
        check("reset_b", 64'({mem_rd_b, mem_addr_b, pb4, pb3, pb2, pb1, pb0, load_end_b,
                              word_b, wv_b, busy_b, done_b, err_b}), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Frame 1: readable during FETCH and stray starts must be ignored
        pulse_start_a();
        for (int c = 2; c <= 82; c++) begin
            @(negedge clk);
            readable_a = (c >= 10 && c <= 15);
            edge_a     = 1'b1;
            start_a    = (c == 20);
        end
        @(negedge clk);
        for (int j = 0; j < 20; j++) exp_a.push_back('{w: 20'h55555, d: (j == 19)});
        for (int i = 0; i < 400; i++) begin
            readable_a = 1'b1;
            edge_a     = (i % 2 == 0);
            start_a    = (i == 100);
            @(negedge clk);
        end
        readable_a = 1'b0;
        start_a    = 1'b0;
        @(negedge clk);
        check("busy_after_done", 64'(busy_a), 64'd0);
        check("done_single_cycle", 64'(done_a), 64'd0);
        check("word_held", 64'(word_a), 64'h55555);
        wait_empty("words_cont_drained", 1'b1);

        // Frame 2: readable 1 cycle on, 3 off
        pulse_start_a();
        repeat (82) @(negedge clk);
        for (int j = 0; j < 20; j++) exp_a.push_back('{w: 20'h55555, d: (j == 19)});
        for (int i = 0; i < 400; i++) begin
            readable_a = 1'b1;
            edge_a     = (i % 2 == 0);
            @(negedge clk);
            readable_a = 1'b0;
            repeat (3) @(negedge clk);
        end
        wait_empty("words_gap_drained", 1'b1);
        check("gap_no_timeout", 64'(err_a), 64'd0);

        // Frame 3: reset at beat 40, then restart and let the full timeout expire
        pulse_start_a();
        repeat (42) @(negedge clk);
        exp_cyc.delete();
        reset = 1'b1;
        #1;
        check("reset_mid_frame", 64'({mem_rd_a, mem_addr_a, pa4, pa3, pa2, pa1, pa0,
                                      load_end_a, word_a, wv_a, busy_a, done_a, err_a}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        pulse_start_a();
        repeat (4176) @(negedge clk);
        check("timeout_a_before", 64'({err_a, busy_a}), 64'b01);
        @(negedge clk);
        check("timeout_a_fired", 64'({err_a, busy_a, done_a}), 64'b100);

        // Small instance: timeout after 16 idle COLLECT cycles
        pulse_start_b();
        check("busy_b_after_start", 64'(busy_b), 64'd1);
        repeat (97) @(negedge clk);
        check("timeout_b_before", 64'({err_b, busy_b}), 64'b01);
        @(negedge clk);
        check("timeout_b_fired", 64'({err_b, busy_b, done_b}), 64'b100);
        repeat (3) @(negedge clk);
        check("timeout_b_sticky", 64'(err_b), 64'd1);

        // Next start clears the error; a partial word is dropped on timeout
        pulse_start_b();
        check("err_b_cleared", 64'({err_b, busy_b}), 64'b01);
        repeat (82) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            readable_b = 1'b1;
            edge_b     = 1'b1;
            @(negedge clk);
        end
        readable_b = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (err_b) break;
            @(negedge clk);
        end
        check("timeout_b_partial", 64'({err_b, busy_b}), 64'b10);

        // Flush: 30 ones -> full word then 10-bit partial with done
        pulse_start_b();
        repeat (82) @(negedge clk);
        exp_b.push_back('{w: 20'hFFFFF, d: 1'b0});
        exp_b.push_back('{w: 20'h003FF, d: 1'b1});
        for (int i = 0; i < 30; i++) begin
            readable_b = 1'b1;
            edge_b     = 1'b1;
            @(negedge clk);
        end
        readable_b = 1'b0;
        wait_empty("words_flush_drained", 1'b0);
        check("flush_state", 64'({err_b, busy_b}), 64'b00);

        repeat (3) @(negedge clk);
        check("frame_queue_empty", 64'(exp_cyc.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
